bcd_convert_ctrl: RTL

- Sequential binary-to-BCD converter controller using the shift-and-add-3 method (double dabble).
- Replaces the combinational compare/subtract/mux path that feeds the seven-segment decoders.
- Accepts a binary value on a start pulse and runs one ADJUST and one SHIFT cycle per input bit.
- Presents registered BCD digits to the per-digit seven-segment decoders, with a done pulse and an overflow flag.

---
 rtl/bcd_convert_ctrl_pkg.sv | 19 +
 rtl/bcd_convert_ctrl_digit_adj.sv | 11 +
 rtl/bcd_convert_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared state encoding and digit-adjust constants for the sequential
// binary-to-BCD (double dabble) converter.
package bcd_convert_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADJUST = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    function automatic logic [3:0] adjust_digit(input logic [3:0] digit);
        return (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;
    endfunction

endpackage

// File: rtl/bcd_convert_ctrl_digit_adj.sv
// Per-digit add-3 correction applied before each shift of the scratch BCD.
module bcd_digit_adj
    import bcd_convert_ctrl_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = adjust_digit(digit_i);

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: one ADJUST and one SHIFT cycle per input
// bit, result and overflow registered together with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start, last result held on bcd_out_o
// ADJUST | add 3 to every scratch digit >= 5
// SHIFT  | shift {scratch, binary} left, collect carry out of the top digit
// DONE   | result presented, done_o high for this single cycle
module bcd_convert_ctrl
    import bcd_convert_ctrl_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_out_o,
    output logic                  overflow_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

    state_e                   state_q;
    logic [BIN_W-1:0]         shift_q;
    logic [BCD_W-1:0]         scratch_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf_acc_q;
    logic                     busy_q;
    logic                     done_q;
    logic [BCD_W-1:0]         bcd_q;
    logic                     ovf_q;

    logic [BCD_W-1:0]         scratch_adj_d;
    logic [BCD_W+BIN_W-1:0]   shifted_d;
    logic                     ovf_next_d;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[4*k +: 4]),
            .digit_o (scratch_adj_d[4*k +: 4])
        );
    end

    assign shifted_d  = {scratch_q, shift_q} << 1;
    // The bit leaving the top digit is a decimal carry past 10^DIGITS-1.
    assign ovf_next_d = ovf_acc_q | scratch_q[BCD_W-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        shift_q   <= bin_in_i;
                        scratch_q <= '0;
                        ovf_acc_q <= 1'b0;
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    scratch_q <= scratch_adj_d;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    scratch_q <= shifted_d[BCD_W+BIN_W-1:BIN_W];
                    shift_q   <= shifted_d[BIN_W-1:0];
                    ovf_acc_q <= ovf_next_d;
                    cnt_q     <= cnt_q - CNT_ONE;
                    // Result is registered on entry to DONE so it is valid with done_o.
                    if (cnt_q == CNT_ONE) begin
                        bcd_q   <= shifted_d[BCD_W+BIN_W-1:BIN_W];
                        ovf_q   <= ovf_next_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_ADJUST;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bcd_out_o  = bcd_q;
    assign overflow_o = ovf_q;

endmodule
